// File: rtl/cic_channel_scheduler.sv
// Time-division scheduler for the shared multichannel CIC integrator chain.
// It round-robins channel samples onto one integrator datapath. It also runs
// the prime / arm / park strobe sequence the integrator sections need around
// every start and stop.
module cic_channel_scheduler #(
    parameter int MIDDLE_WIDTH          = 37,
    parameter int CIC_MAX_CHANNELS      = 16,
    parameter int CIC_CONFIG_DATA_WIDTH = 16,
    parameter int STROBE_LOW            = 1,
    parameter int PRIME_STROBES         = 2
) (
    input  logic                                     CLK,
    input  logic                                     nRST,
    input  logic                                     Cfg_Start,
    input  logic                                     Cfg_Stop,
    input  logic [CIC_CONFIG_DATA_WIDTH-1:0]         Cfg_NumSecs,
    input  logic [CIC_MAX_CHANNELS-1:0]              Cfg_ChMask,
    input  logic [CIC_MAX_CHANNELS-1:0]              Ch_Req,
    input  logic [CIC_MAX_CHANNELS*MIDDLE_WIDTH-1:0] Ch_Data,
    output logic [CIC_MAX_CHANNELS-1:0]              Ch_Ack,
    output logic signed [MIDDLE_WIDTH-1:0]           Sec_Data,
    output logic                                     Sec_Valid,
    output logic [3:0]                               Sec_ChIdx,
    output logic [2:0]                               Sec_StateIdx,
    output logic [CIC_CONFIG_DATA_WIDTH-1:0]         Sec_NumSecs,
    output logic                                     Busy
);

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_ARM, S_RUN, S_PARK} state_t;

    localparam logic [3:0] LOW_SAT  = 4'(STROBE_LOW);
    localparam logic [2:0] PRIME_N  = 3'(PRIME_STROBES);
    localparam logic [2:0] ST_HOLD  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd3;

    state_t                      state;
    logic [CIC_MAX_CHANNELS-1:0] mask;
    logic [3:0]                  ptr;
    logic [3:0]                  low_cnt;   // low cycles since last strobe, saturates
    logic [2:0]                  prime_cnt; // PRIME strobes issued so far
    logic                        stop_l;
    logic                        boundary;
    logic                        stop_now;
    logic                        gnt_found;
    logic [3:0]                  gnt_idx;
    logic [4:0]                  cand;
    logic [15:0]                 elig;
    logic [15:0]                 gnt_onehot;
    logic [MIDDLE_WIDTH-1:0]     ch_data_a [16];

    // Unpack per-channel lanes into a fixed 16-entry view; absent lanes are inert.
    for (genvar g = 0; g < 16; g++) begin : g_lane
        if (g < CIC_MAX_CHANNELS) begin : g_on
            assign ch_data_a[g] = Ch_Data[g*MIDDLE_WIDTH +: MIDDLE_WIDTH];
            assign elig[g]      = Ch_Req[g] & mask[g];
        end else begin : g_off
            assign ch_data_a[g] = '0;
            assign elig[g]      = 1'b0;
        end
    end

    // A slot boundary is the first cycle a new strobe may rise.
    assign boundary   = !Sec_Valid && (low_cnt >= LOW_SAT);
    assign stop_now   = stop_l | Cfg_Stop;
    assign gnt_onehot = 16'd1 << gnt_idx;

    // Round-robin search from ptr+1; scanning backwards lets the nearest eligible win.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = CIC_MAX_CHANNELS; k >= 1; k--) begin
            cand = {1'b0, ptr} + 5'(k);
            if (cand >= 5'(CIC_MAX_CHANNELS))
                cand = cand - 5'(CIC_MAX_CHANNELS);
            if (elig[cand[3:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[3:0];
            end
        end
    end

    // Sequencer FSM with strobe generator; each state is entered on the cycle
    // its (first) strobe is launched, so ARM means the ARM strobe is in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= S_IDLE;
            Sec_Valid    <= 1'b0;
            Ch_Ack       <= '0;
            Sec_Data     <= '0;
            Sec_ChIdx    <= '0;
            Sec_StateIdx <= '0;
            Sec_NumSecs  <= '0;
            Busy         <= 1'b0;
            ptr          <= '0;
            mask         <= '0;
            stop_l       <= 1'b0;
            low_cnt      <= LOW_SAT;
            prime_cnt    <= '0;
        end else begin
            Ch_Ack <= '0;
            if (Sec_Valid) begin
                Sec_Valid <= 1'b0;
                low_cnt   <= 4'd1;
            end else if (low_cnt < LOW_SAT) begin
                low_cnt <= low_cnt + 4'd1;
            end

            case (state)
                S_IDLE: begin
                    // The low phase is always complete in IDLE, so the first
                    // PRIME strobe launches together with the start.
                    if (Cfg_Start) begin
                        Sec_NumSecs  <= Cfg_NumSecs;
                        mask         <= Cfg_ChMask;
                        ptr          <= '0;
                        stop_l       <= 1'b0;
                        Busy         <= 1'b1;
                        Sec_Valid    <= 1'b1;
                        Sec_Data     <= '0;
                        Sec_ChIdx    <= '0;
                        Sec_StateIdx <= ST_HOLD;
                        prime_cnt    <= 3'd1;
                        state        <= S_PRIME;
                    end
                end
                S_PRIME, S_ARM, S_RUN: begin
                    if (Cfg_Stop)
                        stop_l <= 1'b1;
                    if (boundary) begin
                        if (stop_now) begin
                            stop_l       <= 1'b0;
                            Sec_Valid    <= 1'b1;
                            Sec_Data     <= '0;
                            Sec_ChIdx    <= '0;
                            Sec_StateIdx <= ST_HOLD;
                            state        <= S_PARK;
                        end else if (state == S_PRIME) begin
                            Sec_Valid <= 1'b1;
                            Sec_Data  <= '0;
                            Sec_ChIdx <= '0;
                            if (prime_cnt < PRIME_N) begin
                                Sec_StateIdx <= ST_HOLD;
                                prime_cnt    <= prime_cnt + 3'd1;
                            end else begin
                                Sec_StateIdx <= ST_RUN;
                                state        <= S_ARM;
                            end
                        end else begin
                            state <= S_RUN;
                            if (gnt_found) begin
                                Sec_Valid    <= 1'b1;
                                Sec_Data     <= ch_data_a[gnt_idx];
                                Sec_ChIdx    <= gnt_idx;
                                Sec_StateIdx <= ST_RUN;
                                Ch_Ack       <= gnt_onehot[CIC_MAX_CHANNELS-1:0];
                                ptr          <= gnt_idx;
                            end
                        end
                    end
                end
                S_PARK: begin
                    if (boundary) begin
                        state  <= S_IDLE;
                        Busy   <= 1'b0;
                        stop_l <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cic_channel_scheduler.md
# cic_channel_scheduler

Time-division scheduler and sequencer for the shared multichannel CIC integrator chain. It arbitrates up to 16 channel sample sources round-robin onto the single integrator datapath, generating the valid strobe, channel index and stage-state code that the integrator sections consume. It also runs the prime, clear and park sequence those sections need on every start and stop. It sits between the per-channel NCO/mixer outputs and the first integrator section of the DDC.

## Interface
- MIDDLE_WIDTH, 37, sample width on the integrator datapath
- CIC_MAX_CHANNELS, 16, number of channel request lines (1..16)
- CIC_CONFIG_DATA_WIDTH, 16, width of stage-enable mask
- STROBE_LOW, 1, minimum low cycles of Sec_Valid between strobes (1..15)
- PRIME_STROBES, 2, StateIdx=0 strobes issued before clear (1..7)

Ports:
- CLK  in  1  single clock; all logic on rising edge
- nRST  in  1  asynchronous active-low reset
- Cfg_Start  in  1  pulse; latch config and begin sequence (IDLE only)
- Cfg_Stop  in  1  pulse; park chain at next strobe boundary
- Cfg_NumSecs  in  CIC_CONFIG_DATA_WIDTH  stage-enable mask
- Cfg_ChMask  in  CIC_MAX_CHANNELS  enabled channels
- Ch_Req  in  CIC_MAX_CHANNELS  level; channel has a sample ready
- Ch_Data  in  CIC_MAX_CHANNELS*MIDDLE_WIDTH  packed samples, channel i at [i*MIDDLE_WIDTH +: MIDDLE_WIDTH]
- Ch_Ack  out  CIC_MAX_CHANNELS  one-hot, one-cycle grant pulse
- Sec_Data  out  MIDDLE_WIDTH  signed sample to first section
- Sec_Valid  out  1  strobe (sections act on both edges)
- Sec_ChIdx  out  4  channel index of Sec_Data
- Sec_StateIdx  out  3  stage control code: 3'd3 = run, 3'd0 = hold
- Sec_NumSecs  out  CIC_CONFIG_DATA_WIDTH  registered stage-enable mask
- Busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, PRIME, ARM, RUN, PARK. All outputs registered.
- Strobe generator: Sec_Valid high exactly 1 cycle, then low at least STROBE_LOW cycles. Sec_Data, Sec_ChIdx and Sec_StateIdx update only on the cycle Sec_Valid rises and hold until the next rise.
- IDLE: no strobes. Cfg_Start latches Cfg_NumSecs into Sec_NumSecs and Cfg_ChMask into an internal mask, clears the round-robin pointer to 0, and goes to PRIME. Cfg_Stop is ignored. Cfg_Start outside IDLE is ignored.
- PRIME: issues PRIME_STROBES strobes with StateIdx=0, data 0 and ChIdx 0. This moves enabled sections to their wait state, then goes to ARM.
- ARM: issues one strobe with StateIdx=3, data 0, ChIdx 0. This clears section delay lines and output, then goes to RUN.
- RUN: at each slot boundary (low phase complete), select the first channel i with Ch_Req[i] & mask[i], searching from pointer+1 modulo CIC_MAX_CHANNELS. On a grant:
  - raise Sec_Valid with StateIdx=3, ChIdx=i and Data=Ch_Data[i];
  - pulse Ch_Ack[i] in the same cycle;
  - set the pointer to i.
- RUN with no eligible request: no strobe, Sec_Valid stays low, and a grant is evaluated every cycle.
- Cfg_Stop in PRIME, ARM or RUN is latched sticky and honoured at the next slot boundary; any in-flight strobe completes its low phase first. The block then goes to PARK.
- PARK: issues one strobe with StateIdx=0, data 0, ChIdx 0, so sections return to hold. The block then goes to IDLE and Sec_NumSecs keeps its value.
- Cfg_Start and Cfg_Stop in the same cycle in IDLE: start proceeds and stop is dropped.
- Masked channels never receive Ch_Ack, regardless of Ch_Req.
- Reset (any time, including mid-strobe): state IDLE; Sec_Valid, Ch_Ack, Sec_Data, Sec_ChIdx, Sec_StateIdx, Sec_NumSecs, Busy, the pointer and the internal mask all 0; the stop latch is cleared.

## Timing
- Cfg_Start sampled at edge 0. Busy=1 from cycle 1.
- With STROBE_LOW=1 and PRIME_STROBES=2: PRIME strobes rise at cycles 1 and 3, the ARM strobe at cycle 5, and the first RUN strobe at cycle 7 at the earliest.
- Maximum throughput: one sample per 1+STROBE_LOW cycles, shared across all channels.
- Grant latency: Ch_Ack asserts in the first slot-boundary cycle after Ch_Req is seen, provided the channel wins arbitration. Ch_Data must be valid in the Ch_Ack cycle. The source must drop or advance Ch_Req by the next cycle.
- Stop latency: the PARK strobe rises at most 1+STROBE_LOW cycles after Cfg_Stop. Busy falls the cycle after the PARK strobe's low phase ends.

## Test plan
- Reset mid-RUN strobe (nRST low while Sec_Valid=1) -> all outputs 0 immediately, IDLE; a new Cfg_Start replays the full PRIME/ARM sequence.
- Cfg_Start with mask 0x0001, Ch_Req[0] held, Ch_Data[0]=5 -> strobes rise at cycles 1,3 (StateIdx 0), 5 (StateIdx 3, data 0), 7 (StateIdx 3, data 5, ChIdx 0); Ch_Ack[0] at cycle 7, then every 2 cycles.
- Mask 0x000F with all four requesting -> grant order 1,2,3,0,1,...; ChIdx matches each Ch_Ack; no channel is granted twice before the others are served.
- Mask 0x0005 with Ch_Req=0x000F -> only channels 0 and 2 are ever granted; Ch_Ack[1] and Ch_Ack[3] stay 0.
- Cfg_Stop during RUN -> the current strobe completes, one strobe with StateIdx=0 and data 0 follows, then Busy=0; later Ch_Req produces no strobes.
- Ch_Req drops to 0 for 10 cycles in RUN, then Ch_Req[4] rises (STROBE_LOW=3) -> Sec_Valid stays low throughout the gap; a grant is issued the cycle after Ch_Req[4] is seen; subsequent strobes are spaced 4 cycles apart.
